// File: rtl/adder_pkg.sv
// Shared widths and types for the two-stage 32-bit adder responder.
package adder_pkg;
    localparam int ADD_WIDTH  = 32;
    localparam int RES_WIDTH  = 33;
    localparam int HALF_WIDTH = 16;

    typedef logic [ADD_WIDTH-1:0] operand_t;
    typedef logic [RES_WIDTH-1:0] result_t;

    // Stage-1 payload: low half already summed, upper halves waiting for the carry.
    typedef struct packed {
        logic [HALF_WIDTH-1:0] sum_lo;
        logic                  carry;
        logic [HALF_WIDTH-1:0] a_hi;
        logic [HALF_WIDTH-1:0] b_hi;
    } s1_t;

    function automatic result_t finish_sum(input s1_t s1);
        logic [HALF_WIDTH:0] upper;
        upper = (HALF_WIDTH+1)'(s1.a_hi) + (HALF_WIDTH+1)'(s1.b_hi) + (HALF_WIDTH+1)'(s1.carry);
        return {upper, s1.sum_lo};
    endfunction
endpackage

// File: rtl/result_fifo.sv
// Result FIFO; a push on a full FIFO is taken when a pop frees the slot on the same edge.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count < CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/adder_responder.sv
// Two-stage 32+32->33 adder with valid/ready operand intake and a result FIFO.
module adder_responder
    import adder_pkg::*;
#(
    parameter int RES_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [ADD_WIDTH-1:0]          op_a,
    input  logic [ADD_WIDTH-1:0]          op_b,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [RES_WIDTH-1:0]          res_sum,
    output logic [$clog2(RES_DEPTH):0]    res_count,
    output logic [15:0]                   txn_count
);
    localparam int CW = $clog2(RES_DEPTH) + 1;

    logic    init_done;
    logic    vld_p1;
    s1_t     s1_p1;
    result_t sum_p2;
    logic    accept;
    logic    pop;

    // Credit check counts the pair sitting in S1 so the FIFO can never overflow.
    assign op_ready  = init_done && ((res_count + CW'(vld_p1)) < CW'(RES_DEPTH));
    assign accept    = op_valid && op_ready;
    assign res_valid = (res_count != '0);
    assign pop       = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
            vld_p1    <= 1'b0;
            txn_count <= '0;
        end else begin
            init_done <= 1'b1;
            vld_p1    <= accept;
            if (pop) txn_count <= txn_count + 16'd1;
        end
    end

    // Stage 1: low-half sum and carry, upper halves held for stage 2.
    always_ff @(posedge clk) begin
        if (accept) begin
            {s1_p1.carry, s1_p1.sum_lo} <= (HALF_WIDTH+1)'(op_a[HALF_WIDTH-1:0])
                                         + (HALF_WIDTH+1)'(op_b[HALF_WIDTH-1:0]);
            s1_p1.a_hi <= op_a[ADD_WIDTH-1:HALF_WIDTH];
            s1_p1.b_hi <= op_b[ADD_WIDTH-1:HALF_WIDTH];
        end
    end

    // Stage 2: upper-half add, written straight into the FIFO.
    assign sum_p2 = finish_sum(s1_p1);

    result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (RES_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (sum_p2),
        .pop       (pop),
        .pop_data  (res_sum),
        .count     (res_count)
    );
endmodule

// File: tb/tb_adder_responder.sv
// Scoreboard bench for adder_responder: expected sums queued on accept, compared on pop.
module tb_adder_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [32:0] res_sum;
    logic [2:0]  res_count;
    logic [15:0] txn_count;

    logic [32:0] q[$];
    logic [32:0] exp_v;
    int n_pass  = 0;
    int n_total = 0;

    adder_responder #(.RES_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_count (res_count),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    // Drives one cycle's inputs at the falling edge and predicts what the next rising edge does.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic rr, output logic acc, output logic pop);
        @(negedge clk);
        op_valid  = v;
        op_a      = v ? a : 'x;
        op_b      = v ? b : 'x;
        res_ready = rr;
        acc = v && op_ready;
        pop = res_valid && rr;
        if (acc) q.push_back({1'b0, a} + {1'b0, b});
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total += 4;
        if (op_ready !== 1'b0)   $display("FAIL reset_op_ready: got %b want 0", op_ready);   else n_pass++;
        if (res_valid !== 1'b0)  $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
        if (res_count !== 3'd0)  $display("FAIL reset_res_count: got %0d want 0", res_count); else n_pass++;
        if (txn_count !== 16'd0) $display("FAIL reset_txn_count: got %0d want 0", txn_count); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (op_ready !== 1'b1) $display("FAIL release_op_ready: got %b want 1", op_ready); else n_pass++;
    endtask

    task automatic test_single();
        logic acc, pop;
        drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b1, acc, pop);
        n_total++;
        if (acc !== 1'b1) $display("FAIL single_accept: got %b want 1", acc); else n_pass++;
        drive(1'b0, '0, '0, 1'b1, acc, pop);
        n_total++;
        if (res_valid !== 1'b0) $display("FAIL single_no_bypass: res_valid %b want 0", res_valid); else n_pass++;
        drive(1'b0, '0, '0, 1'b1, acc, pop);
        n_total++;
        if (pop !== 1'b1 || res_sum !== 33'h0_0000_0007)
            $display("FAIL single_sum: valid %b sum %h want 1 / 000000007", res_valid, res_sum);
        else n_pass++;
        if (pop && q.size() > 0) exp_v = q.pop_front();
        drive(1'b0, '0, '0, 1'b1, acc, pop);
        n_total += 2;
        if (txn_count !== 16'd1) $display("FAIL single_txn: got %0d want 1", txn_count); else n_pass++;
        if (res_valid !== 1'b0)  $display("FAIL single_empty: res_valid %b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_carry();
        logic acc, pop;
        logic [32:0] lit [2];
        int pops = 0;
        lit[0] = 33'h0_0001_0000;
        lit[1] = 33'h1_FFFF_FFFE;
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, acc, pop);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc, pop);
        for (int c = 0; c < 10 && pops < 2; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, pop);
            if (pop) begin
                n_total++;
                if (q.size() == 0) $display("FAIL carry_pop: unexpected result %h", res_sum);
                else begin
                    exp_v = q.pop_front();
                    if (res_sum !== exp_v || res_sum !== lit[pops])
                        $display("FAIL carry_sum: got %h want %h", res_sum, lit[pops]);
                    else n_pass++;
                end
                pops++;
            end
        end
        n_total++;
        if (pops != 2) $display("FAIL carry_count: got %0d results want 2", pops); else n_pass++;
    endtask

    task automatic test_fill();
        logic acc, pop;
        int accs = 0;
        int pops = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 32'(accs), 32'd1, 1'b0, acc, pop);
            if (acc) accs++;
        end
        drive(1'b0, '0, '0, 1'b0, acc, pop);
        n_total += 3;
        if (accs != 4)          $display("FAIL fill_accepts: got %0d want 4", accs);       else n_pass++;
        if (op_ready !== 1'b0)  $display("FAIL fill_op_ready: got %b want 0", op_ready);   else n_pass++;
        if (res_count !== 3'd4) $display("FAIL fill_count: got %0d want 4", res_count);    else n_pass++;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, pop);
            if (pop) begin
                n_total++;
                if (q.size() == 0) $display("FAIL fill_pop: unexpected result %h", res_sum);
                else begin
                    exp_v = q.pop_front();
                    if (res_sum !== exp_v || res_sum !== 33'(pops + 1))
                        $display("FAIL fill_order: got %h want %h", res_sum, 33'(pops + 1));
                    else n_pass++;
                end
                pops++;
            end
        end
        n_total++;
        if (pops != 4) $display("FAIL fill_drain: got %0d results want 4", pops); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc, pop;
        logic [2:0] ref_cnt = '0;
        for (int c = 0; c < 6; c++) drive(1'b1, $urandom, $urandom, 1'b0, acc, pop);
        n_total++;
        if (res_count !== 3'd4) $display("FAIL stream_full: got %0d want 4", res_count); else n_pass++;
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, $urandom, $urandom, 1'b1, acc, pop);
            if (c == 10) ref_cnt = res_count;
            if (c > 10) begin
                n_total += 2;
                if (res_count !== ref_cnt) $display("FAIL stream_count: got %0d want %0d", res_count, ref_cnt); else n_pass++;
                if (!pop) $display("FAIL stream_rate: res_valid %b want 1", res_valid); else n_pass++;
            end
            if (pop) begin
                n_total++;
                if (q.size() == 0) $display("FAIL stream_pop: unexpected result %h", res_sum);
                else begin
                    exp_v = q.pop_front();
                    if (res_sum !== exp_v) $display("FAIL stream_order: got %h want %h", res_sum, exp_v); else n_pass++;
                end
            end
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, pop);
            if (pop) begin
                n_total++;
                exp_v = q.pop_front();
                if (res_sum !== exp_v) $display("FAIL stream_drain: got %h want %h", res_sum, exp_v); else n_pass++;
            end
        end
        n_total++;
        if (q.size() != 0) $display("FAIL stream_left: %0d results missing want 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic acc, pop;
        for (int c = 0; c < 4; c++) drive(1'b1, $urandom, $urandom, 1'b0, acc, pop);
        drive(1'b0, '0, '0, 1'b0, acc, pop);
        n_total++;
        if (res_count !== 3'd3) $display("FAIL midrst_setup: count %0d want 3", res_count); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total += 4;
        if (res_valid !== 1'b0)  $display("FAIL midrst_valid: got %b want 0", res_valid);   else n_pass++;
        if (res_count !== 3'd0)  $display("FAIL midrst_count: got %0d want 0", res_count);  else n_pass++;
        if (txn_count !== 16'd0) $display("FAIL midrst_txn: got %0d want 0", txn_count);    else n_pass++;
        if (op_ready !== 1'b0)   $display("FAIL midrst_ready: got %b want 0", op_ready);    else n_pass++;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, '0, 1'b1, acc, pop);
            n_total++;
            if (res_valid !== 1'b0) $display("FAIL midrst_stale: res_valid %b sum %h want 0", res_valid, res_sum); else n_pass++;
        end
    endtask

    task automatic test_txn_wrap();
        logic acc, pop;
        int accs = 0;
        int pops = 0;
        for (int c = 0; c < 70000 && pops < 65537; c++) begin
            drive(accs < 65537, $urandom, $urandom, 1'b1, acc, pop);
            if (acc) accs++;
            if (pops == 65536) begin
                n_total++;
                if (txn_count !== 16'd0) $display("FAIL wrap_zero: got %0d want 0", txn_count); else n_pass++;
            end
            if (pop) begin
                n_total++;
                if (q.size() == 0) $display("FAIL wrap_pop: unexpected result %h", res_sum);
                else begin
                    exp_v = q.pop_front();
                    if (res_sum !== exp_v) $display("FAIL wrap_order: got %h want %h", res_sum, exp_v); else n_pass++;
                end
                pops++;
            end
        end
        n_total++;
        if (pops != 65537) $display("FAIL wrap_timeout: got %0d pops want 65537", pops); else n_pass++;
        drive(1'b0, '0, '0, 1'b1, acc, pop);
        n_total++;
        if (txn_count !== 16'd1) $display("FAIL wrap_txn: got %0d want 1", txn_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_txn_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adder_responder.md
ADDER_RESPONDER -- requirements
Module: adder_responder

Interface
REQ-001 SHALL have parameter RES_DEPTH, default 4, result FIFO depth (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port op_valid  input  1  operand pair offered.
REQ-005 SHALL have port op_ready  output  1  responder can accept an operand pair.
REQ-006 SHALL have port op_a  input  32  unsigned operand A.
REQ-007 SHALL have port op_b  input  32  unsigned operand B.
REQ-008 SHALL have port res_valid  output  1  result available at FIFO head.
REQ-009 SHALL have port res_ready  input  1  consumer takes result.
REQ-010 SHALL have port res_sum  output  33  head result; bit 32 is carry-out.
REQ-011 SHALL have port res_count  output  $clog2(RES_DEPTH)+1  results held in FIFO.
REQ-012 SHALL have port txn_count  output  16  results delivered since reset.

Function
REQ-013 SHALL accept an operand pair on an edge where op_valid and op_ready are both high; no other edge accepts.
REQ-014 SHALL compute res_sum = zero-extended op_a + zero-extended op_b, exact 33-bit, no truncation.
REQ-015 SHALL use two stages: S1 registers low 16-bit sum, low carry, upper operand halves; S2 adds upper halves plus carry and writes 33-bit result into FIFO.
REQ-016 SHALL have latency 2: pair accepted at edge k is written to FIFO at edge k+1; with empty FIFO, res_valid high from edge k+1.
REQ-017 SHALL sustain one accept per cycle while FIFO space permits.
REQ-018 SHALL drive op_ready = (res_count + S1_occupied) < RES_DEPTH, combinational from registered state only, never from op_valid.
REQ-019 SHALL pop FIFO head on an edge where res_valid and res_ready are both high; res_sum SHALL hold stable while res_valid high and res_ready low.
REQ-020 SHALL return results strictly in acceptance order.
REQ-021 SHALL, on simultaneous S2 write and pop, keep res_count unchanged and lose no data, including at res_count = RES_DEPTH (pop frees slot same edge).
REQ-022 SHALL, with FIFO empty, not bypass S2: result appears only via FIFO write (no same-cycle passthrough).
REQ-023 SHALL wrap FIFO read/write pointers modulo RES_DEPTH.
REQ-024 SHALL increment txn_count on each pop, wrapping 16'hFFFF -> 0.
REQ-025 SHALL ignore op_a/op_b when not accepting; X on them SHALL NOT propagate.

Reset
REQ-026 SHALL, on rst high, immediately clear S1 valid, FIFO pointers, res_count, txn_count; res_valid = 0, op_ready = 0 while rst high.
REQ-027 SHALL discard any in-flight S1 pair and stored results on reset mid-operation; no result emerges after release.
REQ-028 SHALL assert op_ready on first edge after rst deasserts; res_sum value is don't-care while res_valid low.

Structure
REQ-029 SHALL place ADD_WIDTH = 32, RES_WIDTH = 33, HALF_WIDTH = 16 and typedefs operand_t, result_t in adder_pkg.
REQ-030 SHALL implement FIFO as one sub-module, result_fifo (parameterised depth/width, push/pop/count), all else in adder_responder.

Verification
REQ-031 SHALL cover: single add 32'h0000_0003 + 32'h0000_0004, res_ready=1 -> res_sum 33'h0_0000_0007 two edges after accept, txn_count=1.
REQ-032 SHALL cover: carry across halves 32'h0000_FFFF + 32'h0000_0001 -> 33'h0_0001_0000; and 32'hFFFF_FFFF + 32'hFFFF_FFFF -> 33'h1_FFFF_FFFE.
REQ-033 SHALL cover: res_ready=0, op_valid=1 continuous with a=i, b=1 -> exactly RES_DEPTH (4) accepts, op_ready low, res_count=4; then res_ready=1 -> sums 1,2,3,4 in order, no loss.
REQ-034 SHALL cover: full FIFO, simultaneous push and pop each cycle for 20 cycles -> res_count constant, one result per cycle, order preserved.
REQ-035 SHALL cover: rst asserted mid-edge with S1 occupied and 3 results stored -> res_valid=0, res_count=0, txn_count=0 immediately; no stale result after release.
REQ-036 SHALL cover: 65537 pops -> txn_count = 1 after wrap.
